// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the cpu program loader:
// command bytes, FSM state encoding and word sizes.
package cpu_loader_pkg;

    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;
    localparam logic [7:0] CMD_HALT   = 8'h04;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_CNT_LO = 3'd1;
    localparam state_t ST_CNT_HI = 3'd2;
    localparam state_t ST_ADR_LO = 3'd3;
    localparam state_t ST_ADR_HI = 3'd4;
    localparam state_t ST_DATA   = 3'd5;
    localparam state_t ST_WRITE  = 3'd6;

    localparam int WORD_BYTES_I = 4;
    localparam int WORD_BYTES_D = 8;

    function automatic logic is_load(input logic [7:0] b);
        return (b == CMD_LOAD_I) || (b == CMD_LOAD_D);
    endfunction

endpackage

// File: rtl/loader_word_packer.sv
// LSB-first byte packer: assembles 4-byte (IMEM) or
// 8-byte (DMEM) words from the loader byte stream.
module loader_word_packer
    import cpu_loader_pkg::*;
(
    input  logic        clk,
    input  logic        arst_n,
    input  logic        clear,
    input  logic        take,
    input  logic        mode_d,
    input  logic [7:0]  byte_in,
    output logic        last,
    output logic [63:0] word_nxt
);

    logic [63:0] sr;
    logic [2:0]  cnt;
    logic [63:0] word_sh;

    // Shifted value including the byte being accepted this cycle
    always_comb begin
        word_sh  = {byte_in, sr[63:8]};
        word_nxt = mode_d ? word_sh : {32'b0, word_sh[63:32]};
        last     = (cnt == (mode_d ? 3'(WORD_BYTES_D - 1)
                                   : 3'(WORD_BYTES_I - 1)));
    end

    // Shift register and byte counter; counter wraps after each word
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clear) begin
            sr  <= '0;
            cnt <= '0;
        end else if (take) begin
            sr  <= word_sh;
            cnt <= last ? 3'd0 : cnt + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Byte-stream boot loader: writes IMEM/DMEM through the
// cpu external ports and controls the cpu run enable.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_ADDR_W = 9,
    parameter int DMEM_ADDR_W = 10
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        busy,
    output logic        err
);

    localparam int IDX_W = (IMEM_ADDR_W > DMEM_ADDR_W) ?
                           IMEM_ADDR_W : DMEM_ADDR_W;

    state_t            state;
    state_t            state_nxt;
    logic              mode_d;
    logic [15:0]       cnt;
    logic [7:0]        adr_lo;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              pk_last;
    logic [63:0]       pk_word;
    logic              word_done;

    assign accept    = s_valid & s_ready;
    assign word_done = (state == ST_DATA) & accept & pk_last;

    loader_word_packer u_packer (
        .clk      (clk),
        .arst_n   (arst_n),
        .clear    (state == ST_IDLE),
        .take     (accept && (state == ST_DATA)),
        .mode_d   (mode_d),
        .byte_in  (s_data),
        .last     (pk_last),
        .word_nxt (pk_word)
    );

    // FSM state register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:
                if (accept && is_load(s_data)) state_nxt = ST_CNT_LO;
            ST_CNT_LO:
                if (accept) state_nxt = ST_CNT_HI;
            ST_CNT_HI:
                if (accept) state_nxt = ST_ADR_LO;
            ST_ADR_LO:
                if (accept) state_nxt = ST_ADR_HI;
            ST_ADR_HI:
                if (accept)
                    state_nxt = (cnt == 16'd0) ? ST_IDLE : ST_DATA;
            ST_DATA:
                if (accept && pk_last) state_nxt = ST_WRITE;
            ST_WRITE:
                state_nxt = (cnt == 16'd1) ? ST_IDLE : ST_DATA;
            default:
                state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs; strobes come straight from the WRITE state
    always_comb begin
        s_ready   = (state != ST_WRITE);
        busy      = (state != ST_IDLE);
        wen_ext   = (state == ST_WRITE) & ~mode_d;
        wen_ext_2 = (state == ST_WRITE) &  mode_d;
    end

    // Frame header capture, remaining count and word index
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mode_d <= 1'b0;
            cnt    <= '0;
            adr_lo <= '0;
            idx    <= '0;
        end else begin
            unique case (state)
                ST_IDLE:
                    if (accept && is_load(s_data))
                        mode_d <= (s_data == CMD_LOAD_D);
                ST_CNT_LO:
                    if (accept) cnt[7:0] <= s_data;
                ST_CNT_HI:
                    if (accept) cnt[15:8] <= s_data;
                ST_ADR_LO:
                    if (accept) adr_lo <= s_data;
                ST_ADR_HI:
                    if (accept) idx <= IDX_W'({s_data, adr_lo});
                ST_WRITE: begin
                    cnt <= cnt - 16'd1;
                    idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Run enable and unknown-command error pulse
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            enable <= 1'b0;
            err    <= 1'b0;
        end else begin
            err <= 1'b0;
            if (state == ST_IDLE && accept) begin
                unique case (s_data)
                    CMD_LOAD_I, CMD_LOAD_D, CMD_HALT: enable <= 1'b0;
                    CMD_RUN:                          enable <= 1'b1;
                    default:                          err    <= 1'b1;
                endcase
            end
        end
    end

    // Write ports load when a word completes and hold until the next one
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            addr_ext    <= '0;
            wdata_ext   <= '0;
            addr_ext_2  <= '0;
            wdata_ext_2 <= '0;
        end else if (word_done) begin
            if (mode_d) begin
                addr_ext_2  <= 64'({idx[DMEM_ADDR_W-1:0], 3'b000});
                wdata_ext_2 <= pk_word;
            end else begin
                addr_ext  <= 64'({idx[IMEM_ADDR_W-1:0], 2'b00});
                wdata_ext <= pk_word[31:0];
            end
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: command table,
// scoreboarded load frames, back-pressure and reset corners.
module tb_cpu_program_loader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        enable;
    logic        busy;
    logic        err;

    cpu_program_loader dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .enable      (enable),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          d;
        logic [63:0] addr;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] b;
        logic       en;
        logic       er;
    } vec_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    logic [63:0] wq[$];
    vec_t        vt[7];
    int          tests = 0;
    int          fails = 0;
    int          stall = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arst_n === 1'b1) begin
            check("wen_exclusive", {63'b0, wen_ext & wen_ext_2}, 64'd0);
            if (wen_ext || wen_ext_2) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_wen: got i=%b d=%b expected none",
                             wen_ext, wen_ext_2);
                end else begin
                    mon_e = sbq.pop_front();
                    check("wen_port", {63'b0, wen_ext_2}, {63'b0, mon_e.d});
                    if (mon_e.d) begin
                        check("addr_d", addr_ext_2, mon_e.addr);
                        check("data_d", wdata_ext_2, mon_e.data);
                    end else begin
                        check("addr_i", addr_ext, mon_e.addr);
                        check("data_i", {32'b0, wdata_ext}, mon_e.data);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int g;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        g = 0;
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        stall = g;
        if (g >= 50) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got s_ready=0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic load(input bit d, input int cnt, input int adr);
        logic [63:0] w;
        exp_t        e;
        int          nb;
        nb = d ? 8 : 4;
        send_byte(d ? 8'h02 : 8'h01);
        send_byte(cnt[7:0]);
        send_byte(cnt[15:8]);
        send_byte(adr[7:0]);
        send_byte(adr[15:8]);
        for (int k = 0; k < cnt; k++) begin
            w = wq.pop_front();
            e.d = d;
            if (d) begin
                e.addr = 64'(((adr + k) % 1024) * 8);
                e.data = w;
            end else begin
                e.addr = 64'(((adr + k) % 512) * 4);
                e.data = {32'b0, w[31:0]};
            end
            sbq.push_back(e);
            for (int j = 0; j < nb; j++) begin
                send_byte(w[8*j +: 8]);
                if (k > 0 && j == 0) check("stall_write", 64'(stall), 64'd1);
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        if (cnt > 0) check("latency", {63'b0, wen_ext | wen_ext_2}, 64'd1);
        @(negedge clk);
        check("busy_after", {63'b0, busy}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{8'h03, 1'b1, 1'b0};
        vt[1] = '{8'h04, 1'b0, 1'b0};
        vt[2] = '{8'h03, 1'b1, 1'b0};
        vt[3] = '{8'h7F, 1'b1, 1'b1};
        vt[4] = '{8'h04, 1'b0, 1'b0};
        vt[5] = '{8'h7F, 1'b0, 1'b1};
        vt[6] = '{8'h03, 1'b1, 1'b0};

        arst_n  = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h01;
        #22;
        check("rst_ready", {63'b0, s_ready}, 64'd1);
        check("rst_enable", {63'b0, enable}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_wen", {62'b0, wen_ext, wen_ext_2}, 64'd0);
        check("rst_err", {63'b0, err}, 64'd0);
        check("rst_addr", addr_ext | addr_ext_2, 64'd0);
        @(negedge clk);
        s_valid = 1'b0;
        arst_n  = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_byte(vt[i].b);
            @(negedge clk);
            s_valid = 1'b0;
            check("cmd_enable", {63'b0, enable}, {63'b0, vt[i].en});
            check("cmd_err", {63'b0, err}, {63'b0, vt[i].er});
            check("cmd_busy", {63'b0, busy}, 64'd0);
            @(negedge clk);
            check("err_pulse", {63'b0, err}, 64'd0);
        end

        load(1'b0, 0, 0);
        check("load0_enable", {63'b0, enable}, 64'd0);
        send_byte(8'h03);
        @(negedge clk);
        s_valid = 1'b0;
        check("run_enable", {63'b0, enable}, 64'd1);

        wq.push_back(64'h00100013);
        wq.push_back(64'h00200093);
        load(1'b0, 2, 5);
        check("load_i_enable", {63'b0, enable}, 64'd0);
        repeat (3) @(negedge clk);
        check("hold_addr_i", addr_ext, 64'h18);
        check("hold_data_i", {32'b0, wdata_ext}, 64'h00200093);

        wq.push_back(64'h1122334455667788);
        load(1'b1, 1, 16'h03FF);
        wq.push_back(64'h0303030303030303);
        wq.push_back(64'hCAFEF00D12345603);
        load(1'b1, 2, 16'h03FF);
        check("data_run_enable", {63'b0, enable}, 64'd0);
        check("hold_addr_d", addr_ext_2, 64'h0);
        check("hold_i_untouched", addr_ext, 64'h18);

        wq.push_back(64'hA5A5_0F0F);
        load(1'b0, 1, 16'hFE05);

        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        @(negedge clk);
        s_valid = 1'b0;
        arst_n  = 1'b0;
        #1;
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_ready", {63'b0, s_ready}, 64'd1);
        check("midrst_wen", {62'b0, wen_ext, wen_ext_2}, 64'd0);
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        wq.push_back(64'hDEADBEEF);
        load(1'b0, 1, 2);

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
